wb_stage_q: RTL and testbench
=============================

# wb_stage_q

Parametrised write-back stage placed after the memory stage, replacing the fixed single-cycle write-back. It selects the result source (ALU address/result, aligned load data, or link address), performs byte/halfword load extraction with sign/zero extension, and queues results in a DEPTH-entry FIFO. The FIFO drains into the register-file write port under a grant signal, so a shared or busy write port back-pressures the memory stage instead of dropping writes.

## Interface
Parameters:
- DEPTH, 4, result FIFO entries; power of two, ≥2
- RFADDR_W, 5, register address width (4 for RV32E builds)

Ports:
- clk  in  1  pipeline clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- memwbValid  in  1  a result is offered this cycle
- memwbReady  out  1  stage can accept (FIFO not full)
- memwbData  in  32  raw 32-bit word read from data memory
- memwbAddr  in  32  ALU result / memory address
- memwbLink  in  32  PC+4 for JAL/JALR
- memwbRd  in  RFADDR_W  destination register
- memwbFunct3  in  3  load width/sign (RISC-V encoding)
- memwbWbCtrl  in  3  [1:0] source select, [2] register write enable
- rfGrant  in  1  register-file write port available this cycle
- regwrite  out  1  write strobe to register file
- writebackData  out  32  value to write
- wbRd  out  RFADDR_W  register to write
- wbValid  out  1  FIFO head holds an entry (for hazard/forward logic)
- retireCount  out  64  retired-entry count (see Configuration)

## Operation
- Source select memwbWbCtrl[1:0]: 00 memwbAddr; 01 aligned load data; 10 memwbLink; 11 memwbAddr.
- Load alignment, off = memwbAddr[1:0]: funct3 000 LB byte at off, sign-extend; 001 LH half at off[1], sign-extend (off[0] ignored, no misalign trap); 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend half; 011/110/111 raw word.
- Selection and alignment are combinational on input; FIFO stores the final 32-bit value, rd, and effective write-enable.
- Effective write-enable = memwbWbCtrl[2] AND memwbRd≠0; x0 writes are stored as non-writing entries (still occupy a slot, still retire).
- Push: memwbValid && memwbReady at rising edge.
- Pop: wbValid && rfGrant at rising edge.
- Outputs from FIFO head: wbRd, writebackData = head fields when wbValid, else 0; regwrite = wbValid && rfGrant && head write-enable.
- memwbReady = NOT full; registered from occupancy, no combinational dependence on rfGrant (no pop-through when full).
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, order preserved.
- Push and pop pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Reset (async, rstn low): FIFO empty, pointers/occupancy 0, wbValid 0, regwrite 0, writebackData 0, wbRd 0, memwbReady 1, retireCount 0. Reset mid-operation discards all queued entries.
- Latency: entry accepted at edge N is at head and visible on outputs in cycle N+1 (if FIFO was empty); earliest register write at edge N+1.
- Throughput: one entry per cycle with rfGrant held high.
- Full: memwbReady low from the cycle after occupancy reaches DEPTH; returns high the cycle after a pop.
- memwbValid while memwbReady low: input ignored; upstream holds it.

## Configuration
- WB_RETIRE_CNT_EN defined: retireCount is a 64-bit counter incremented on every pop (including x0/non-writing entries), wraps at 2^64−1 to 0, reset to 0.
- Not defined: counter logic absent, retireCount tied to 0.

## Test plan
- Reset then push ALU result: Addr=0x0000_1234, Ctrl=3'b100, Rd=5, rfGrant=1 -> cycle after push regwrite=1, wbRd=5, writebackData=0x0000_1234.
- Load extraction: Data=0x80FF_7F01; LB off=3 -> 0xFFFF_FF80; LBU off=2 -> 0x0000_00FF; LH off=2 -> 0xFFFF_80FF; LHU off=0 -> 0x0000_7F01; LW -> 0x80FF_7F01.
- Back-pressure: rfGrant=0, push 4 entries (DEPTH=4) -> memwbReady=0, 5th offer not accepted; raise rfGrant -> 4 entries retire in order, one per cycle, memwbReady=1 after first pop.
- x0 and JAL: Rd=0 Ctrl=3'b100 -> regwrite stays 0, entry retires; Ctrl=3'b110, Link=0x104, Rd=1 -> writebackData=0x104, regwrite=1.
- Async reset with 3 entries queued, mid-cycle -> outputs 0, wbValid=0, memwbReady=1 immediately; no stale writes after release.
- With WB_RETIRE_CNT_EN: 10 pops -> retireCount=10; without it -> retireCount=0.

Source files
------------

// File: rtl/wb_stage_q.sv
// wb_stage_q: write-back stage with result queue.
//
// Selects the write-back value (ALU result, aligned load data or link
// address), extracts and extends byte/halfword loads, then queues
// {value, rd, write-enable} in a DEPTH-entry FIFO. The FIFO head drives the
// register-file write port and only retires when rfGrant is high, so a busy
// write port back-pressures the memory stage rather than losing writes.
//
// Optional feature: define WB_RETIRE_CNT_EN to build the 64-bit retire
// counter; otherwise retireCount is tied to zero.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   memwbValid/Ready handshake from the memory stage (Ready = FIFO not full)
//   memwbData        raw data-memory word
//   memwbAddr        ALU result / memory address
//   memwbLink        PC+4 for JAL/JALR
//   memwbRd          destination register
//   memwbFunct3      load width/sign
//   memwbWbCtrl      [1:0] source select, [2] register write enable
//   rfGrant          register-file write port available
//   regwrite         register-file write strobe
//   writebackData    value to write (0 when queue empty)
//   wbRd             register to write (0 when queue empty)
//   wbValid          queue head holds an entry
//   retireCount      number of retired entries
module wb_stage_q #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RFADDR_W = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                memwbValid,
  output logic                memwbReady,
  input  logic [31:0]         memwbData,
  input  logic [31:0]         memwbAddr,
  input  logic [31:0]         memwbLink,
  input  logic [RFADDR_W-1:0] memwbRd,
  input  logic [2:0]          memwbFunct3,
  input  logic [2:0]          memwbWbCtrl,
  input  logic                rfGrant,
  output logic                regwrite,
  output logic [31:0]         writebackData,
  output logic [RFADDR_W-1:0] wbRd,
  output logic                wbValid,
  output logic [63:0]         retireCount
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Source selection and load alignment
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] in_data;
  logic        in_we;

  always_comb begin
    ld_byte = memwbData[7:0];
    unique case (memwbAddr[1:0])
      2'd0: ld_byte = memwbData[7:0];
      2'd1: ld_byte = memwbData[15:8];
      2'd2: ld_byte = memwbData[23:16];
      2'd3: ld_byte = memwbData[31:24];
      default: ld_byte = memwbData[7:0];
    endcase
    // Halfword offset bit 0 is ignored: misaligned halves are not trapped.
    ld_half = memwbAddr[1] ? memwbData[31:16] : memwbData[15:0];

    unique case (memwbFunct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = memwbData;
    endcase

    unique case (memwbWbCtrl[1:0])
      2'b01:   in_data = ld_data;
      2'b10:   in_data = memwbLink;
      default: in_data = memwbAddr;
    endcase

    // x0 entries still take a slot and retire, but never write.
    in_we = memwbWbCtrl[2] && (memwbRd != '0);
  end

  // Result FIFO
  logic [31:0]         data_q [DEPTH];
  logic [RFADDR_W-1:0] rd_q   [DEPTH];
  logic                we_q   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, full;

  assign full       = (count_q == CntW'(DEPTH));
  // Depends only on stored occupancy: no pop-through when full.
  assign memwbReady = ~full;
  assign wbValid    = (count_q != '0);
  assign push       = memwbValid && memwbReady;
  assign pop        = wbValid && rfGrant;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head fields are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= in_data;
      rd_q[wr_ptr_q]   <= memwbRd;
      we_q[wr_ptr_q]   <= in_we;
    end
  end

  assign writebackData = wbValid ? data_q[rd_ptr_q] : '0;
  assign wbRd          = wbValid ? rd_q[rd_ptr_q] : '0;
  assign regwrite      = pop && we_q[rd_ptr_q];

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_q, retire_d;

  assign retire_d = pop ? retire_q + 64'd1 : retire_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retireCount = retire_q;
`else
  assign retireCount = '0;
`endif

endmodule

// File: tb/tb_wb_stage_q.sv
// Directed testbench for wb_stage_q (DEPTH=4, RFADDR_W=5).
module tb_wb_stage_q;

  logic        clk;
  logic        rstn;
  logic        memwbValid;
  logic        memwbReady;
  logic [31:0] memwbData;
  logic [31:0] memwbAddr;
  logic [31:0] memwbLink;
  logic [4:0]  memwbRd;
  logic [2:0]  memwbFunct3;
  logic [2:0]  memwbWbCtrl;
  logic        rfGrant;
  logic        regwrite;
  logic [31:0] writebackData;
  logic [4:0]  wbRd;
  logic        wbValid;
  logic [63:0] retireCount;

  int errors;
  int checks;

  wb_stage_q #(
    .DEPTH   (4),
    .RFADDR_W(5)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .memwbValid   (memwbValid),
    .memwbReady   (memwbReady),
    .memwbData    (memwbData),
    .memwbAddr    (memwbAddr),
    .memwbLink    (memwbLink),
    .memwbRd      (memwbRd),
    .memwbFunct3  (memwbFunct3),
    .memwbWbCtrl  (memwbWbCtrl),
    .rfGrant      (rfGrant),
    .regwrite     (regwrite),
    .writebackData(writebackData),
    .wbRd         (wbRd),
    .wbValid      (wbValid),
    .retireCount  (retireCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] link;
    logic [4:0]  rd;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ctrl, input logic [2:0] f3, input logic [31:0] data,
                       input logic [31:0] addr, input logic [31:0] link, input logic [4:0] rd);
    memwbValid  = 1'b1;
    memwbWbCtrl = ctrl;
    memwbFunct3 = f3;
    memwbData   = data;
    memwbAddr   = addr;
    memwbLink   = link;
    memwbRd     = rd;
  endtask

  logic [63:0] exp_retire;

  initial begin
    errors = 0;
    checks = 0;

    //              ctrl    f3      data          addr          link       rd    we    expected
    vecs[0]  = '{3'b100, 3'b010, 32'h0,        32'h0000_1234, 32'h0,     5'd5, 1'b1, 32'h0000_1234};
    vecs[1]  = '{3'b101, 3'b000, 32'h80FF_7F01, 32'h0000_1003, 32'h0,     5'd6, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{3'b101, 3'b100, 32'h80FF_7F01, 32'h0000_2002, 32'h0,     5'd7, 1'b1, 32'h0000_00FF};
    vecs[3]  = '{3'b101, 3'b001, 32'h80FF_7F01, 32'h0000_2002, 32'h0,     5'd8, 1'b1, 32'hFFFF_80FF};
    vecs[4]  = '{3'b101, 3'b101, 32'h80FF_7F01, 32'h0000_2000, 32'h0,     5'd9, 1'b1, 32'h0000_7F01};
    vecs[5]  = '{3'b101, 3'b010, 32'h80FF_7F01, 32'h0000_2000, 32'h0,    5'd10, 1'b1, 32'h80FF_7F01};
    vecs[6]  = '{3'b101, 3'b001, 32'h80FF_7F01, 32'h0000_2003, 32'h0,    5'd11, 1'b1, 32'hFFFF_80FF};
    vecs[7]  = '{3'b101, 3'b011, 32'h80FF_7F01, 32'h0000_2001, 32'h0,    5'd12, 1'b1, 32'h80FF_7F01};
    vecs[8]  = '{3'b100, 3'b000, 32'h0,        32'h0000_DEAD, 32'h0,     5'd0, 1'b0, 32'h0000_DEAD};
    vecs[9]  = '{3'b110, 3'b000, 32'h0,        32'h0000_0040, 32'h104,   5'd1, 1'b1, 32'h0000_0104};
    vecs[10] = '{3'b111, 3'b000, 32'h0,        32'h0000_55AA, 32'h104,   5'd7, 1'b1, 32'h0000_55AA};
    vecs[11] = '{3'b001, 3'b000, 32'h80FF_7F01, 32'h0000_2000, 32'h0,    5'd9, 1'b0, 32'h0000_0001};
    vecs[12] = '{3'b101, 3'b000, 32'h80FF_7F01, 32'h0000_2001, 32'h0,   5'd13, 1'b1, 32'h0000_007F};

    rstn       = 1'b0;
    rfGrant    = 1'b0;
    memwbValid = 1'b0;
    drive(3'b0, 3'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    memwbValid = 1'b0;

    #12;
    chk("reset_wbValid", 64'(wbValid), 64'd0);
    chk("reset_regwrite", 64'(regwrite), 64'd0);
    chk("reset_data", 64'(writebackData), 64'd0);
    chk("reset_wbRd", 64'(wbRd), 64'd0);
    chk("reset_ready", 64'(memwbReady), 64'd1);
    chk("reset_retire", retireCount, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Table: push one entry, check it at the head with grant high, let it pop.
    rfGrant = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].f3, vecs[i].data, vecs[i].addr, vecs[i].link, vecs[i].rd);
      @(posedge clk);
      #1;
      memwbValid = 1'b0;
      chk($sformatf("vec%0d_wbValid", i), 64'(wbValid), 64'd1);
      chk($sformatf("vec%0d_regwrite", i), 64'(regwrite), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_wbRd", i), 64'(wbRd), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_data", i), 64'(writebackData), 64'(vecs[i].exp_data));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_drained", i), 64'(wbValid), 64'd0);
    end

    // Back-pressure: fill with grant low, 5th offer must be ignored.
    @(negedge clk);
    rfGrant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b100, 3'b000, 32'h0, 32'h100 + 32'(i), 32'h0, 5'(i + 1));
      @(posedge clk);
      #1;
      chk($sformatf("fill%0d_regwrite", i), 64'(regwrite), 64'd0);
      chk($sformatf("fill%0d_ready", i), 64'(memwbReady), (i == 3) ? 64'd0 : 64'd1);
      @(negedge clk);
    end
    drive(3'b100, 3'b000, 32'h0, 32'h999, 32'h0, 5'd20);
    @(posedge clk);
    #1;
    chk("full_ready_held", 64'(memwbReady), 64'd0);
    chk("full_head_kept", 64'(writebackData), 64'h100);
    @(negedge clk);
    memwbValid = 1'b0;
    rfGrant    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d_regwrite", i), 64'(regwrite), 64'd1);
      chk($sformatf("drain%0d_data", i), 64'(writebackData), 64'h100 + 64'(i));
      chk($sformatf("drain%0d_wbRd", i), 64'(wbRd), 64'(i + 1));
      @(posedge clk);
      #1;
      chk($sformatf("drain%0d_ready", i), 64'(memwbReady), 64'd1);
      @(negedge clk);
    end
    chk("drain_empty", 64'(wbValid), 64'd0);

    // Async reset mid-cycle with 3 entries queued.
    rfGrant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'b100, 3'b000, 32'h0, 32'hA00 + 32'(i), 32'h0, 5'(i + 2));
      @(posedge clk);
      @(negedge clk);
    end
    memwbValid = 1'b0;
    chk("pre_reset_wbValid", 64'(wbValid), 64'd1);
    #2;
    rfGrant = 1'b1;
    rstn    = 1'b0;
    #1;
    chk("areset_wbValid", 64'(wbValid), 64'd0);
    chk("areset_regwrite", 64'(regwrite), 64'd0);
    chk("areset_data", 64'(writebackData), 64'd0);
    chk("areset_wbRd", 64'(wbRd), 64'd0);
    chk("areset_ready", 64'(memwbReady), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset%0d_regwrite", i), 64'(regwrite), 64'd0);
      chk($sformatf("post_reset%0d_wbValid", i), 64'(wbValid), 64'd0);
    end

    // Streaming: one entry per cycle with grant held, then count retirements.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(3'b100, 3'b000, 32'h0, 32'h300 + 32'(i), 32'h0, (i == 3) ? 5'd0 : 5'(i + 1));
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_data", i), 64'(writebackData), 64'h300 + 64'(i));
      chk($sformatf("stream%0d_regwrite", i), 64'(regwrite), (i == 3) ? 64'd0 : 64'd1);
    end
    @(negedge clk);
    memwbValid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_empty", 64'(wbValid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
    exp_retire = 64'd10;
`else
    exp_retire = 64'd0;
`endif
    chk("retire_count", retireCount, exp_retire);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
